id_slot_alloc: RTL and testbench



---
 rtl/id_slot_alloc_if.sv | 34 +++
 rtl/id_slot_alloc.sv | 111 +++++++++++
 tb/tb_id_slot_alloc.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_slot_alloc_if.sv
// Allocation, release and status bundle between issue logic and the ID slot allocator.
// Latency: none (wires only).
// Backpressure: alloc_ready_o gates allocation; releases are never backpressured.
interface id_slot_alloc_if #(
    parameter int IdCapacity = 16,
    parameter int NumRel     = 2
);
    localparam int IdxW = $clog2(IdCapacity);
    localparam int CntW = $clog2(IdCapacity + 1);

    logic                           flush_i;
    logic                           alloc_valid_i;
    logic                           alloc_ready_o;
    logic [IdxW-1:0]                alloc_idx_o;
    logic [NumRel-1:0]              rel_valid_i;
    logic [NumRel-1:0][IdxW-1:0]    rel_idx_i;
    logic [IdCapacity-1:0]          free_o;
    logic [CntW-1:0]                used_cnt_o;
    logic                           full_o;
    logic                           empty_o;
    logic                           err_o;

    // Issue logic / tracking table side
    modport master (
        output flush_i, alloc_valid_i, rel_valid_i, rel_idx_i,
        input  alloc_ready_o, alloc_idx_o, free_o, used_cnt_o, full_o, empty_o, err_o
    );

    // Allocator side
    modport slave (
        input  flush_i, alloc_valid_i, rel_valid_i, rel_idx_i,
        output alloc_ready_o, alloc_idx_o, free_o, used_cnt_o, full_o, empty_o, err_o
    );
endinterface

// File: rtl/id_slot_alloc.sv
// Free/busy bitmap allocator: grants the lowest free slot, reclaims slots from NumRel release ports.
// Latency: grant visible combinationally from registered state; bitmap/count/status update 1 cycle after handshake.
// Backpressure: alloc_ready_o low when no slot is free or flush is active; releases always accepted.
module id_slot_alloc #(
    parameter  int IdCapacity = 16,
    parameter  int NumRel     = 2,
    localparam int IdxW       = $clog2(IdCapacity),
    localparam int CntW       = $clog2(IdCapacity + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    id_slot_alloc_if.slave      bus
);

    logic [IdCapacity-1:0] free_q;
    logic [IdCapacity-1:0] free_d;
    logic [CntW-1:0]       cnt_q;
    logic [CntW-1:0]       cnt_d;
    logic                  err_q;

    logic [IdxW-1:0]       grant_idx;
    logic                  alloc_ready;
    logic                  alloc_fire;
    logic [IdCapacity-1:0] alloc_onehot;
    logic [IdCapacity-1:0] rel_mask;
    logic                  rel_err;
    logic [CntW-1:0]       rel_cnt;

    // Lowest free slot; scanning downwards lets the lowest index win.
    always_comb begin
        grant_idx = '0;
        for (int i = IdCapacity - 1; i >= 0; i--) begin
            if (free_q[i]) grant_idx = IdxW'(i);
        end
    end

    // Flush blocks grants so a slot is never handed out while the table is being cleared.
    assign alloc_ready = (|free_q) && !bus.flush_i;
    assign alloc_fire  = bus.alloc_valid_i && alloc_ready;

    // One-hot of the slot being taken this cycle.
    always_comb begin
        alloc_onehot = '0;
        for (int s = 0; s < IdCapacity; s++) begin
            alloc_onehot[s] = alloc_fire && (grant_idx == IdxW'(s));
        end
    end

    // Release decode: OR-ing into a mask merges duplicate releases of one busy slot;
    // out-of-range indices match no slot and releases of free slots are dropped, both flagged.
    always_comb begin
        logic in_range;
        rel_mask = '0;
        rel_err  = 1'b0;
        in_range = 1'b0;
        for (int p = 0; p < NumRel; p++) begin
            in_range = 1'b0;
            if (bus.rel_valid_i[p]) begin
                for (int s = 0; s < IdCapacity; s++) begin
                    if (bus.rel_idx_i[p] == IdxW'(s)) begin
                        in_range = 1'b1;
                        if (free_q[s]) rel_err     = 1'b1;
                        else           rel_mask[s] = 1'b1;
                    end
                end
                if (!in_range) rel_err = 1'b1;
            end
        end
    end

    // Number of distinct slots legally released this cycle.
    always_comb begin
        rel_cnt = '0;
        for (int s = 0; s < IdCapacity; s++) begin
            rel_cnt = rel_cnt + CntW'(rel_mask[s]);
        end
    end

    // Next bitmap and count. Release and allocation masks are disjoint (busy vs free slots),
    // so the order of applying them does not matter; flush overrides both.
    always_comb begin
        free_d = (free_q | rel_mask) & ~alloc_onehot;
        cnt_d  = cnt_q + CntW'(alloc_fire) - rel_cnt;
        if (bus.flush_i) begin
            free_d = '1;
            cnt_d  = '0;
        end
    end

    // State registers; error flag is sticky until reset and ignores flush cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            free_q <= '1;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            free_q <= free_d;
            cnt_q  <= cnt_d;
            err_q  <= err_q | (rel_err & !bus.flush_i);
        end
    end

    assign bus.alloc_ready_o = alloc_ready;
    assign bus.alloc_idx_o   = grant_idx;
    assign bus.free_o        = free_q;
    assign bus.used_cnt_o    = cnt_q;
    assign bus.full_o        = (cnt_q == CntW'(IdCapacity));
    assign bus.empty_o       = (cnt_q == '0);
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_id_slot_alloc.sv
// Self-checking bench for id_slot_alloc: directed scenarios plus randomized traffic against a bitmap model.
// Latency: checks sampled 1 time unit after the rising edge.
// Backpressure: allocations only counted when the model says a slot is free and flush is low.
module tb_id_slot_alloc;
    localparam int CAP   = 16;
    localparam int NREL  = 2;
    localparam int CAP_B = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_slot_alloc_if #(.IdCapacity(CAP),   .NumRel(NREL)) bus   ();
    id_slot_alloc_if #(.IdCapacity(CAP_B), .NumRel(NREL)) bus_b ();

    id_slot_alloc #(.IdCapacity(CAP),   .NumRel(NREL)) dut   (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));
    id_slot_alloc #(.IdCapacity(CAP_B), .NumRel(NREL)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(bus_b.slave));

    int errors = 0;
    int checks = 0;

    // Reference model: a plain array of free flags and a sticky error bit.
    bit m_free[CAP];
    bit m_err;

    function automatic int m_lowest();
        for (int i = 0; i < CAP; i++) if (m_free[i]) return i;
        return 0;
    endfunction

    function automatic int m_used();
        int n = 0;
        for (int i = 0; i < CAP; i++) if (!m_free[i]) n++;
        return n;
    endfunction

    function automatic bit m_any();
        for (int i = 0; i < CAP; i++) if (m_free[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [CAP-1:0] m_vec();
        logic [CAP-1:0] v;
        for (int i = 0; i < CAP; i++) v[i] = m_free[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < CAP; i++) m_free[i] = 1'b1;
        m_err = 1'b0;
    endtask

    // Advance one clock, applying the allocator rules to the model from the driven inputs.
    task automatic cycle();
        bit nf[CAP];
        nf = m_free;
        if (bus.flush_i) begin
            for (int i = 0; i < CAP; i++) nf[i] = 1'b1;
        end else begin
            for (int p = 0; p < NREL; p++) begin
                if (bus.rel_valid_i[p]) begin
                    int ix = int'(bus.rel_idx_i[p]);
                    if (ix >= CAP || m_free[ix]) m_err = 1'b1;
                    else nf[ix] = 1'b1;
                end
            end
            if (bus.alloc_valid_i && m_any()) nf[m_lowest()] = 1'b0;
        end
        @(posedge clk);
        #1;
        m_free = nf;
    endtask

    task automatic idle_inputs();
        bus.flush_i = 0; bus.alloc_valid_i = 0; bus.rel_valid_i = '0; bus.rel_idx_i = '0;
        bus_b.flush_i = 0; bus_b.alloc_valid_i = 0; bus_b.rel_valid_i = '0; bus_b.rel_idx_i = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        m_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 7;
        if (bus.free_o !== 16'hFFFF) begin errors++; $display("FAIL reset_free got=%h exp=%h", bus.free_o, 16'hFFFF); end
        if (bus.used_cnt_o !== 5'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.used_cnt_o); end
        if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty_o); end
        if (bus.full_o !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full_o); end
        if (bus.alloc_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.alloc_ready_o); end
        if (bus.alloc_idx_o !== 4'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", bus.alloc_idx_o); end
        if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < CAP; k++) begin
            checks += 2;
            if (bus.alloc_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, bus.alloc_ready_o); end
            if (int'(bus.alloc_idx_o) !== k) begin errors++; $display("FAIL b2b_idx got=%0d exp=%0d", bus.alloc_idx_o, k); end
            bus.alloc_valid_i = 1'b1;
            cycle();
        end
        bus.alloc_valid_i = 1'b0;
        checks += 4;
        if (bus.full_o !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", bus.full_o); end
        if (bus.alloc_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", bus.alloc_ready_o); end
        if (bus.used_cnt_o !== 5'd16) begin errors++; $display("FAIL full_cnt got=%0d exp=16", bus.used_cnt_o); end
        if (bus.free_o !== 16'h0000) begin errors++; $display("FAIL full_free got=%h exp=0000", bus.free_o); end
    endtask

    task automatic test_release_at_full();
        bus.rel_valid_i = 2'b01; bus.rel_idx_i[0] = 4'd5;
        cycle();
        bus.rel_valid_i = '0;
        checks += 4;
        if (bus.alloc_idx_o !== 4'd5) begin errors++; $display("FAIL relfull_idx got=%0d exp=5", bus.alloc_idx_o); end
        if (bus.alloc_ready_o !== 1'b1) begin errors++; $display("FAIL relfull_ready got=%b exp=1", bus.alloc_ready_o); end
        if (bus.used_cnt_o !== 5'd15) begin errors++; $display("FAIL relfull_cnt got=%0d exp=15", bus.used_cnt_o); end
        if (bus.full_o !== 1'b0) begin errors++; $display("FAIL relfull_full got=%b exp=0", bus.full_o); end
        bus.alloc_valid_i = 1'b1;
        cycle();
        bus.alloc_valid_i = 1'b0;
        checks += 2;
        if (bus.used_cnt_o !== 5'd16) begin errors++; $display("FAIL realloc_cnt got=%0d exp=16", bus.used_cnt_o); end
        if (bus.full_o !== 1'b1) begin errors++; $display("FAIL realloc_full got=%b exp=1", bus.full_o); end
    endtask

    task automatic test_dual_release();
        bus.rel_valid_i = 2'b11; bus.rel_idx_i[0] = 4'd3; bus.rel_idx_i[1] = 4'd9;
        cycle();
        bus.rel_valid_i = '0;
        checks += 3;
        if (bus.used_cnt_o !== 5'd14) begin errors++; $display("FAIL dual_cnt got=%0d exp=14", bus.used_cnt_o); end
        if (bus.free_o !== 16'h0208) begin errors++; $display("FAIL dual_free got=%h exp=0208", bus.free_o); end
        if (bus.err_o !== 1'b0) begin errors++; $display("FAIL dual_err got=%b exp=0", bus.err_o); end
        // Refill slots 3 then 9 in order
        bus.alloc_valid_i = 1'b1;
        checks += 1;
        if (bus.alloc_idx_o !== 4'd3) begin errors++; $display("FAIL dual_regrant3 got=%0d exp=3", bus.alloc_idx_o); end
        cycle();
        checks += 1;
        if (bus.alloc_idx_o !== 4'd9) begin errors++; $display("FAIL dual_regrant9 got=%0d exp=9", bus.alloc_idx_o); end
        cycle();
        bus.alloc_valid_i = 1'b0;
        // Both ports on slot 3: one release, no error
        bus.rel_valid_i = 2'b11; bus.rel_idx_i[0] = 4'd3; bus.rel_idx_i[1] = 4'd3;
        cycle();
        bus.rel_valid_i = '0;
        checks += 3;
        if (bus.used_cnt_o !== 5'd15) begin errors++; $display("FAIL same_cnt got=%0d exp=15", bus.used_cnt_o); end
        if (bus.free_o !== 16'h0008) begin errors++; $display("FAIL same_free got=%h exp=0008", bus.free_o); end
        if (bus.err_o !== 1'b0) begin errors++; $display("FAIL same_err got=%b exp=0", bus.err_o); end
    endtask

    task automatic test_illegal_release();
        // Slot 3 is free; release slot 7 legally, then release 7 again (now free)
        bus.rel_valid_i = 2'b10; bus.rel_idx_i[1] = 4'd7;
        cycle();
        checks += 1;
        if (bus.err_o !== 1'b0) begin errors++; $display("FAIL legal7_err got=%b exp=0", bus.err_o); end
        cycle();
        bus.rel_valid_i = '0;
        checks += 3;
        if (bus.err_o !== 1'b1) begin errors++; $display("FAIL illegal7_err got=%b exp=1", bus.err_o); end
        if (bus.free_o !== 16'h0088) begin errors++; $display("FAIL illegal7_free got=%h exp=0088", bus.free_o); end
        if (bus.used_cnt_o !== 5'd14) begin errors++; $display("FAIL illegal7_cnt got=%0d exp=14", bus.used_cnt_o); end
        // Out-of-range index on the 12-slot instance
        bus_b.alloc_valid_i = 1'b1;
        @(posedge clk); #1;
        bus_b.alloc_valid_i = 1'b0;
        bus_b.rel_valid_i = 2'b01; bus_b.rel_idx_i[0] = 4'd13;
        @(posedge clk); #1;
        bus_b.rel_valid_i = '0;
        checks += 3;
        if (bus_b.err_o !== 1'b1) begin errors++; $display("FAIL oor_err got=%b exp=1", bus_b.err_o); end
        if (bus_b.free_o !== 12'hFFE) begin errors++; $display("FAIL oor_free got=%h exp=ffe", bus_b.free_o); end
        if (bus_b.used_cnt_o !== 4'd1) begin errors++; $display("FAIL oor_cnt got=%0d exp=1", bus_b.used_cnt_o); end
        // Error survives flush
        bus.flush_i = 1'b1; bus_b.flush_i = 1'b1;
        cycle();
        bus.flush_i = 1'b0; bus_b.flush_i = 1'b0;
        checks += 3;
        if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_after_flush got=%b exp=1", bus.err_o); end
        if (bus_b.err_o !== 1'b1) begin errors++; $display("FAIL oor_err_after_flush got=%b exp=1", bus_b.err_o); end
        if (bus.used_cnt_o !== 5'd0) begin errors++; $display("FAIL flush_cnt got=%0d exp=0", bus.used_cnt_o); end
    endtask

    task automatic test_flush();
        bus.alloc_valid_i = 1'b1;
        repeat (10) cycle();
        checks += 1;
        if (bus.used_cnt_o !== 5'd10) begin errors++; $display("FAIL pre_flush_cnt got=%0d exp=10", bus.used_cnt_o); end
        bus.flush_i = 1'b1;
        #1;
        checks += 1;
        if (bus.alloc_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", bus.alloc_ready_o); end
        cycle();
        bus.flush_i = 1'b0; bus.alloc_valid_i = 1'b0;
        checks += 3;
        if (bus.free_o !== 16'hFFFF) begin errors++; $display("FAIL flush_free got=%h exp=ffff", bus.free_o); end
        if (bus.used_cnt_o !== 5'd0) begin errors++; $display("FAIL flush_cnt2 got=%0d exp=0", bus.used_cnt_o); end
        if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b exp=1", bus.empty_o); end
    endtask

    task automatic test_async_reset();
        bus.alloc_valid_i = 1'b1;
        repeat (6) cycle();
        // Keep a handshake pending across the reset assertion
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        checks += 6;
        if (bus.free_o !== 16'hFFFF) begin errors++; $display("FAIL arst_free got=%h exp=ffff", bus.free_o); end
        if (bus.used_cnt_o !== 5'd0) begin errors++; $display("FAIL arst_cnt got=%0d exp=0", bus.used_cnt_o); end
        if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL arst_empty got=%b exp=1", bus.empty_o); end
        if (bus.err_o !== 1'b0) begin errors++; $display("FAIL arst_err got=%b exp=0", bus.err_o); end
        if (bus.alloc_idx_o !== 4'd0) begin errors++; $display("FAIL arst_idx got=%0d exp=0", bus.alloc_idx_o); end
        if (bus.alloc_ready_o !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", bus.alloc_ready_o); end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        bus.alloc_valid_i = 1'b0;
        checks += 1;
        if (bus.free_o !== 16'hFFFE) begin errors++; $display("FAIL arst_first_alloc got=%h exp=fffe", bus.free_o); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.alloc_valid_i = 1'($urandom_range(0, 2) != 0);
            bus.flush_i       = 1'($urandom_range(0, 39) == 0);
            for (int p = 0; p < NREL; p++) begin
                int pick = $urandom_range(0, CAP - 1);
                // Bias towards busy slots so most releases are legal
                if ($urandom_range(0, 3) != 0) begin
                    for (int t = 0; t < CAP; t++) begin
                        if (!m_free[(pick + t) % CAP]) begin pick = (pick + t) % CAP; break; end
                    end
                end
                bus.rel_valid_i[p] = 1'($urandom_range(0, 2) == 0);
                bus.rel_idx_i[p]   = 4'(pick);
            end
            #1;
            checks += 2;
            if (bus.alloc_ready_o !== (m_any() && !bus.flush_i)) begin
                errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, bus.alloc_ready_o, m_any() && !bus.flush_i);
            end
            if (int'(bus.alloc_idx_o) !== m_lowest()) begin
                errors++; $display("FAIL rnd_idx n=%0d got=%0d exp=%0d", n, bus.alloc_idx_o, m_lowest());
            end
            cycle();
            checks += 5;
            if (bus.free_o !== m_vec()) begin errors++; $display("FAIL rnd_free n=%0d got=%h exp=%h", n, bus.free_o, m_vec()); end
            if (int'(bus.used_cnt_o) !== m_used()) begin errors++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, bus.used_cnt_o, m_used()); end
            if (bus.full_o !== (m_used() == CAP)) begin errors++; $display("FAIL rnd_full n=%0d got=%b exp=%b", n, bus.full_o, m_used() == CAP); end
            if (bus.empty_o !== (m_used() == 0)) begin errors++; $display("FAIL rnd_empty n=%0d got=%b exp=%b", n, bus.empty_o, m_used() == 0); end
            if (bus.err_o !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, bus.err_o, m_err); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_release_at_full();
        test_dual_release();
        test_illegal_release();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
